// File: rtl/key_store_arb_if.sv
// Bundle of the push/pop signals of key_store_arb.
// The master side is the producers and the consumer; the slave side is the key store.
interface key_store_arb_if #(
  parameter int D_L = 9,
  parameter int W   = 1,
  parameter int N   = 2
);
  logic [N-1:0]   i_v;
  logic [N-1:0]   i_r;
  logic [D_L-1:0] i_k;
  logic [N*W-1:0] i_d;
  logic           o_r;
  logic [D_L-1:0] o_k;
  logic [W-1:0]   o_d;
  logic           o_err;
  logic [D_L:0]   occ;
  logic           rdy;

  modport master (
    output i_v, i_d, o_r, o_k,
    input  i_r, i_k, o_d, o_err, occ, rdy
  );

  modport slave (
    input  i_v, i_d, o_r, o_k,
    output i_r, i_k, o_d, o_err, occ, rdy
  );
endinterface

// File: rtl/key_store_arb.sv
// Round-robin multi-channel key store: free-list pool of D keys with per-key data RAM.
// Define KEY_STORE_ARB_CHECK_EN to reject pops of unallocated keys and flag them on o_err.
//
// state  | meaning
// S_INIT | filling the free list with keys 0..D-1, one per cycle; no grants, pops ignored
// S_RUN  | granting free keys to producers, accepting pops from the consumer
module key_store_arb #(
  parameter int D   = 512,
  parameter int D_L = $clog2(D),
  parameter int W   = 1,
  parameter int N   = 2
) (
  input logic            clk,
  input logic            rst,
  key_store_arb_if.slave bus
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t         state, state_nxt;
  logic [D_L-1:0] init_cnt;
  logic [D_L-1:0] head, tail;
  logic [D_L:0]   fcnt;
  logic [RW-1:0]  rr;
  logic [D_L-1:0] free_list [D];
  logic [W-1:0]   data_ram  [D];

  logic           grant;
  logic [RW-1:0]  gsel;
  logic [N-1:0]   ir;
  logic [D_L-1:0] key_out;
  logic           pop_req, pop_ok;
  logic           fl_we;
  logic [D_L-1:0] fl_wa, fl_wd;
  logic [W-1:0]   od;

  assign key_out = free_list[head];

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    int idx;
    state_nxt = state;
    grant     = 1'b0;
    gsel      = '0;
    ir        = '0;
    pop_req   = 1'b0;
    fl_we     = 1'b0;
    fl_wa     = '0;
    fl_wd     = '0;
    idx       = 0;
    case (state)
      S_INIT: begin
        fl_we = 1'b1;
        fl_wa = init_cnt;
        fl_wd = init_cnt;
        if (init_cnt == D_L'(D - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!rst && fcnt != '0) begin
          for (int off = 0; off < N; off++) begin
            idx = (int'(rr) + off) % N;
            if (!grant && bus.i_v[idx]) begin
              grant = 1'b1;
              gsel  = RW'(idx);
            end
          end
        end
        if (grant) ir[gsel] = 1'b1;
        pop_req = !rst && bus.o_r;
      end
      default: state_nxt = S_INIT;
    endcase
    if (state == S_RUN && pop_ok) begin
      fl_we = 1'b1;
      fl_wa = tail;
      fl_wd = bus.o_k;
    end
  end

`ifdef KEY_STORE_ARB_CHECK_EN
  logic [D-1:0] alloc;
  logic         err;

  // A key granted this very cycle is not yet allocated as far as a pop is concerned.
  assign pop_ok = pop_req && alloc[bus.o_k] && !(grant && bus.o_k == key_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc <= '0;
      err   <= 1'b0;
    end else begin
      if (grant)  alloc[key_out] <= 1'b1;
      if (pop_ok) alloc[bus.o_k] <= 1'b0;
      err <= pop_req && !pop_ok;
    end
  end

  assign bus.o_err = err;
`else
  assign pop_ok    = pop_req;
  assign bus.o_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      head     <= '0;
      tail     <= '0;
      fcnt     <= '0;
      rr       <= '0;
      od       <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (state_nxt == S_RUN) fcnt <= (D_L+1)'(D);
    end else begin
      if (grant) begin
        head <= head + 1'b1;
        rr   <= (gsel == RW'(N - 1)) ? '0 : gsel + 1'b1;
      end
      if (pop_ok) tail <= tail + 1'b1;
      // A pop never feeds a grant in the same cycle, so both terms use the old count.
      case ({grant, pop_ok})
        2'b10:   fcnt <= fcnt - 1'b1;
        2'b01:   fcnt <= fcnt + 1'b1;
        default: fcnt <= fcnt;
      endcase
      if (pop_req) od <= data_ram[bus.o_k];
    end
  end

  always_ff @(posedge clk) begin
    if (fl_we) free_list[fl_wa] <= fl_wd;
    if (grant) data_ram[key_out] <= bus.i_d[int'(gsel)*W +: W];
  end

  assign bus.i_r = ir;
  assign bus.i_k = key_out;
  assign bus.o_d = od;
  assign bus.rdy = (state == S_RUN);
  assign bus.occ = (state == S_RUN) ? (D_L+1)'(D) - fcnt : '0;
endmodule
